// File: rtl/csm_pkg.sv
// rtl/csm_pkg.sv - shared types and encodings for the multi-port shared-memory controller
package csm_pkg;

  // Per-port status codes returned alongside ack
  typedef enum logic [1:0] {
    OK      = 2'b00,
    LOCKED  = 2'b01,
    BAD_REL = 2'b10,
    BAD_CMD = 2'b11
  } err_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Plain constants for the controller state register
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_WDATA = WDATA;
  localparam logic [1:0] S_RESP  = RESP;

endpackage

// File: rtl/csm_rr_arbiter.sv
// rtl/csm_rr_arbiter.sv - round-robin request arbiter with its own rotating pointer
module csm_rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] index
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel;
  logic          found;
  int            cand;

  // Pick the first requester at or after rr_ptr, wrapping around
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N) cand = cand - N;
      sel = IW'(cand);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        index      = sel;
      end
    end
  end

  // Move the pointer just past the winner whenever a grant is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (index == IW'(N - 1)) ? '0 : index + 1'b1;
    end
  end

endmodule

// File: rtl/csm_mp_ctrl.sv
// rtl/csm_mp_ctrl.sv - N-port shared-memory controller with round-robin grant and hold lock
module csm_mp_ctrl
  import csm_pkg::*;
#(
  parameter int NPROC        = 4,
  parameter int DATABITS     = 8,
  parameter int ERRBITS      = 2,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NPROC-1:0][DATABITS-1:0]    in_AD,
  input  logic [NPROC-1:0]                  rw,
  input  logic [NPROC-1:0]                  enable,
  input  logic [NPROC-1:0]                  hold,
  // lock release request ("release" itself is a reserved word)
  input  logic [NPROC-1:0]                  release_req,
  output logic [NPROC-1:0]                  ack,
  output logic [NPROC-1:0][ERRBITS-1:0]     err,
  output logic [NPROC-1:0][DATABITS-1:0]    out_data
);
  localparam int IW = $clog2(NPROC);
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(LOCK_TIMEOUT);

  logic [1:0]          state;
  logic [IW-1:0]       gnt_idx;
  logic [IW-1:0]       arb_idx;
  logic [IW-1:0]       lock_owner;
  logic [NPROC-1:0]    gnt_oh;
  logic [NPROC-1:0]    arb_grant;
  logic [DATABITS-1:0] wr_addr;
  logic                lock_valid;
  logic                tick;
  logic [TW-1:0]       timer;
  logic                new_grant;
  logic                owner_grant;
  logic                expire;
  logic [DATABITS-1:0] mem [2**DATABITS];

  assign new_grant   = (state == S_IDLE) && (|enable);
  assign owner_grant = new_grant && lock_valid && (lock_owner == arb_idx);
  // An owner grant on the expiry edge refreshes the lock instead of losing it
  assign expire      = (LOCK_TIMEOUT != 0) && lock_valid && (timer == TIMEOUT_VAL) && !owner_grant;

  csm_rr_arbiter #(.N(NPROC)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (enable),
    .advance (new_grant),
    .grant   (arb_grant),
    .index   (arb_idx)
  );

  // Controller FSM, command decode, lock ownership and idle timer
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ack        <= '0;
      err        <= '0;
      out_data   <= '0;
      gnt_idx    <= '0;
      gnt_oh     <= '0;
      wr_addr    <= '0;
      lock_valid <= 1'b0;
      lock_owner <= '0;
      timer      <= '0;
      tick       <= 1'b0;
    end else begin
      ack <= '0;

      // timer advances on every second cycle of a held, unused lock
      if (owner_grant || !lock_valid || expire) begin
        timer <= '0;
        tick  <= 1'b0;
      end else begin
        tick <= ~tick;
        if (tick) timer <= timer + 1'b1;
      end
      if (expire) lock_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (new_grant) begin
            gnt_idx <= arb_idx;
            gnt_oh  <= arb_grant;
            state   <= S_RESP;
            ack     <= arb_grant;
            // decode sees the lock as it was before any same-edge expiry
            if (hold[arb_idx] && release_req[arb_idx]) begin
              err[arb_idx] <= ERRBITS'(BAD_CMD);
            end else if (lock_valid && (lock_owner != arb_idx)) begin
              err[arb_idx] <= ERRBITS'(LOCKED);
            end else if (hold[arb_idx]) begin
              lock_valid   <= 1'b1;
              lock_owner   <= arb_idx;
              err[arb_idx] <= ERRBITS'(OK);
            end else if (release_req[arb_idx]) begin
              if (lock_valid) begin
                lock_valid   <= 1'b0;
                err[arb_idx] <= ERRBITS'(OK);
              end else begin
                err[arb_idx] <= ERRBITS'(BAD_REL);
              end
            end else if (!rw[arb_idx]) begin
              out_data[arb_idx] <= mem[in_AD[arb_idx]];
              err[arb_idx]      <= ERRBITS'(OK);
            end else begin
              wr_addr <= in_AD[arb_idx];
              state   <= S_WDATA;
              ack     <= '0;
            end
          end
        end
        S_WDATA: begin
          err[gnt_idx] <= ERRBITS'(OK);
          ack          <= gnt_oh;
          state        <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory write on the data cycle; a reset on that edge drops the write
  always_ff @(posedge clk) begin
    if (!reset && (state == S_WDATA)) begin
      mem[wr_addr] <= in_AD[gnt_idx];
    end
  end

endmodule

// File: tb/tb_csm_mp_ctrl.sv
// tb/tb_csm_mp_ctrl.sv - directed self-checking bench for the shared-memory controller
module tb_csm_mp_ctrl;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0][7:0] in_ad;
  logic [3:0]      rw;
  logic [3:0]      enable;
  logic [3:0]      hold;
  logic [3:0]      rel;
  logic [3:0]      ack;
  logic [3:0][1:0] err;
  logic [3:0][7:0] out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csm_mp_ctrl #(
    .NPROC(4), .DATABITS(8), .ERRBITS(2), .LOCK_TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_AD       (in_ad),
    .rw          (rw),
    .enable      (enable),
    .hold        (hold),
    .release_req (rel),
    .ack         (ack),
    .err         (err),
    .out_data    (out_data)
  );

  // Issue one command on port p and wait (bounded) for its ack.
  // lat counts negedges from the drive point to the first ack seen; -1 if none.
  task automatic do_cmd(input int p, input bit w, input bit h, input bit r,
                        input logic [7:0] a, input logic [7:0] d,
                        output logic [3:0] ack_seen, output logic [1:0] err_seen,
                        output int lat);
    @(negedge clk);
    in_ad[p] = a; rw[p] = w; hold[p] = h; rel[p] = r; enable[p] = 1'b1;
    ack_seen = '0; err_seen = '0; lat = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      enable[p] = 1'b0; hold[p] = 1'b0; rel[p] = 1'b0; in_ad[p] = d;
      if (ack !== 4'b0000) begin
        ack_seen = ack; err_seen = err[p]; lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_ad = '0; rw = '0; enable = '0; hold = '0; rel = '0;
    repeat (3) @(negedge clk);
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", ack); end
    total++; if (err !== 8'h00) begin bad++; $display("FAIL reset_err got=%h want=00", err); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out got=%h want=00000000", out_data); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    logic [3:0] a; logic [1:0] e; int l;
    do_cmd(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'hA5, a, e, l);
    total++; if (a !== 4'b0001 || e !== 2'b00 || l != 2) begin bad++;
      $display("FAIL wr_p0 ack=%b err=%b lat=%0d want ack=0001 err=00 lat=2", a, e, l); end
    @(negedge clk);
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL ack_pulse got=%b want=0000", ack); end
    do_cmd(2, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, a, e, l);
    total++; if (a !== 4'b0100 || e !== 2'b00 || l != 1) begin bad++;
      $display("FAIL rd_p2 ack=%b err=%b lat=%0d want ack=0100 err=00 lat=1", a, e, l); end
    total++; if (out_data[2] !== 8'hA5) begin bad++; $display("FAIL rd_p2_data got=%h want=a5", out_data[2]); end
  endtask

  task automatic test_round_robin();
    logic [3:0] a; logic [1:0] e; int l;
    logic [7:0] exp_d [4];
    int order [4];
    int when  [4];
    int n;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    for (int p = 0; p < 4; p++) do_cmd(0, 1'b1, 1'b0, 1'b0, 8'(p + 1), exp_d[p], a, e, l);
    // reset restarts the pointer at port 0 and leaves memory intact
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int p = 0; p < 4; p++) begin in_ad[p] = 8'(p + 1); rw[p] = 1'b0; end
    enable = 4'b1111;
    n = 0;
    for (int c = 1; c <= 12 && n < 4; c++) begin
      @(negedge clk);
      total++; if ($countones(ack) > 1) begin bad++; $display("FAIL rr_onehot got=%b want=at most one bit", ack); end
      for (int p = 0; p < 4; p++) begin
        if (ack[p] === 1'b1) begin
          order[n] = p; when[n] = c; n++;
          enable[p] = 1'b0;
          total++; if (out_data[p] !== exp_d[p] || err[p] !== 2'b00) begin bad++;
            $display("FAIL rr_data p%0d data=%h err=%b want data=%h err=00", p, out_data[p], err[p], exp_d[p]); end
        end
      end
    end
    enable = '0;
    total++; if (n != 4) begin bad++; $display("FAIL rr_count got=%0d want=4", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (order[i] != i || when[i] != 1 + 2 * i) begin bad++;
        $display("FAIL rr_order slot%0d port=%0d at=%0d want port=%0d at=%0d", i, order[i], when[i], i, 1 + 2 * i); end
    end
  endtask

  task automatic test_lock();
    logic [3:0] a; logic [1:0] e; int l;
    do_cmd(3, 1'b1, 1'b0, 1'b0, 8'h20, 8'h99, a, e, l);
    do_cmd(1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, a, e, l);
    total++; if (a !== 4'b0010 || e !== 2'b00 || l != 1) begin bad++;
      $display("FAIL hold_p1 ack=%b err=%b lat=%0d want ack=0010 err=00 lat=1", a, e, l); end
    do_cmd(3, 1'b1, 1'b0, 1'b0, 8'h20, 8'h55, a, e, l);
    total++; if (a !== 4'b1000 || e !== 2'b01 || l != 1) begin bad++;
      $display("FAIL locked_wr_p3 ack=%b err=%b lat=%0d want ack=1000 err=01 lat=1", a, e, l); end
    do_cmd(1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, a, e, l);
    total++; if (out_data[1] !== 8'h99 || e !== 2'b00) begin bad++;
      $display("FAIL lock_mem_kept got=%h err=%b want=99 err=00", out_data[1], e); end
    do_cmd(1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h77, a, e, l);
    total++; if (a !== 4'b0010 || e !== 2'b00 || l != 2) begin bad++;
      $display("FAIL owner_wr ack=%b err=%b lat=%0d want ack=0010 err=00 lat=2", a, e, l); end
    do_cmd(1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, a, e, l);
    total++; if (e !== 2'b00 || l != 1) begin bad++; $display("FAIL owner_rel err=%b lat=%0d want err=00 lat=1", e, l); end
    do_cmd(3, 1'b1, 1'b0, 1'b0, 8'h20, 8'h55, a, e, l);
    total++; if (a !== 4'b1000 || e !== 2'b00 || l != 2) begin bad++;
      $display("FAIL retry_p3 ack=%b err=%b lat=%0d want ack=1000 err=00 lat=2", a, e, l); end
    do_cmd(0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, a, e, l);
    total++; if (out_data[0] !== 8'h55) begin bad++; $display("FAIL retry_data got=%h want=55", out_data[0]); end
  endtask

  task automatic test_bad_cmd();
    logic [3:0] a; logic [1:0] e; int l;
    do_cmd(2, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, a, e, l);
    total++; if (a !== 4'b0100 || e !== 2'b10) begin bad++; $display("FAIL bad_rel ack=%b err=%b want ack=0100 err=10", a, e); end
    do_cmd(0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, a, e, l);
    total++; if (a !== 4'b0001 || e !== 2'b11) begin bad++; $display("FAIL bad_cmd_unlocked ack=%b err=%b want ack=0001 err=11", a, e); end
    do_cmd(2, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, a, e, l);
    total++; if (e !== 2'b10) begin bad++; $display("FAIL still_unlocked err=%b want=10", e); end
    do_cmd(0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, a, e, l);
    do_cmd(0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, a, e, l);
    total++; if (e !== 2'b11) begin bad++; $display("FAIL bad_cmd_owner err=%b want=11", e); end
    do_cmd(2, 1'b1, 1'b0, 1'b0, 8'h21, 8'h01, a, e, l);
    total++; if (e !== 2'b01 || l != 1) begin bad++; $display("FAIL lock_kept err=%b lat=%0d want err=01 lat=1", e, l); end
    do_cmd(0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, a, e, l);
    total++; if (e !== 2'b00) begin bad++; $display("FAIL bad_cmd_cleanup err=%b want=00", e); end
  endtask

  task automatic test_timeout();
    logic [3:0] a; logic [1:0] e; int l;
    do_cmd(0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, a, e, l);
    total++; if (e !== 2'b00) begin bad++; $display("FAIL to_hold err=%b want=00", e); end
    repeat (3) @(negedge clk);
    do_cmd(1, 1'b1, 1'b0, 1'b0, 8'h30, 8'h12, a, e, l);
    total++; if (e !== 2'b01 || l != 1) begin bad++; $display("FAIL to_early err=%b lat=%0d want err=01 lat=1", e, l); end
    repeat (30) @(negedge clk);
    do_cmd(1, 1'b1, 1'b0, 1'b0, 8'h30, 8'h66, a, e, l);
    total++; if (a !== 4'b0010 || e !== 2'b00 || l != 2) begin bad++;
      $display("FAIL to_expired ack=%b err=%b lat=%0d want ack=0010 err=00 lat=2", a, e, l); end
    do_cmd(1, 1'b0, 1'b0, 1'b0, 8'h30, 8'h00, a, e, l);
    total++; if (out_data[1] !== 8'h66) begin bad++; $display("FAIL to_data got=%h want=66", out_data[1]); end
    do_cmd(0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, a, e, l);
    total++; if (e !== 2'b10) begin bad++; $display("FAIL to_rel err=%b want=10", e); end
  endtask

  task automatic test_reset_mid_write();
    logic [3:0] a; logic [1:0] e; int l;
    int seen;
    do_cmd(1, 1'b1, 1'b0, 1'b0, 8'h40, 8'hC3, a, e, l);
    @(negedge clk);
    in_ad[1] = 8'h40; rw[1] = 1'b1; enable[1] = 1'b1;
    @(negedge clk);
    enable[1] = 1'b0; in_ad[1] = 8'h3C; reset = 1'b1;
    @(negedge clk);
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL mid_ack got=%b want=0000", ack); end
    total++; if (err !== 8'h00) begin bad++; $display("FAIL mid_err got=%h want=00", err); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL mid_out got=%h want=00000000", out_data); end
    reset = 1'b0; rw[1] = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (ack !== 4'b0000) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_late_ack got=%0d want=0", seen); end
    do_cmd(1, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00, a, e, l);
    total++; if (out_data[1] !== 8'hC3 || l != 1) begin bad++;
      $display("FAIL mid_mem got=%h lat=%0d want=c3 lat=1", out_data[1], l); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock();
    test_bad_cmd();
    test_timeout();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
